ru_dump_reader: RTL
===================

# ru_dump_reader

Sequential read-out engine for the processor's 32×32 register file. On a start request it walks a contiguous range of register addresses through one spare combinational read port of the register file. It presents each register index and value to a downstream consumer (debug UART framer, trace buffer) over a valid/ready stream, then pulses done. It is the reading end of the register file and replaces simulation-only register printing with synthesizable hardware.

## Interface
Parameters:
- NREGS, 32, number of architectural registers; addresses wrap modulo NREGS
- ADDR_W, 5, register address width (log2 NREGS)
- DATA_W, 32, register data width

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- DumpStart  in  1  start request; sampled only in IDLE
- DumpFirst  in  ADDR_W  first register index; latched at accepted start
- DumpLast  in  ADDR_W  last register index, inclusive; latched at accepted start
- DumpAbort  in  1  cancel an active dump
- RUrsAddr  out  ADDR_W  address driven to the register file read port
- RUrsData  in  DATA_W  combinational read data for RUrsAddr
- DumpValid  out  1  DumpAddr/DumpData hold a word
- DumpReady  in  1  consumer accepts the word this cycle
- DumpAddr  out  ADDR_W  index of the presented word
- DumpData  out  DATA_W  value of the presented word
- DumpBusy  out  1  high in every state except IDLE
- DumpDone  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE: if DumpStart=1, latch cur=DumpFirst and last=DumpLast, then go to FETCH. Otherwise stay in IDLE.
- FETCH: on the clock edge, capture RUrsData into DumpData and cur into DumpAddr, set DumpValid=1, and go to SEND.
- SEND: hold DumpValid and the data until DumpValid&DumpReady. On that handshake:
  - if cur==last, clear DumpValid and go to DONE;
  - else set cur=(cur+1) mod NREGS, clear DumpValid, and go to FETCH.
- DONE: DumpDone=1 for exactly this cycle, then go to IDLE.
- RUrsAddr always equals cur. cur is a registered address.
- Range wrap: if DumpFirst>DumpLast, addresses wrap, e.g. 30,31,0,1. If DumpFirst==DumpLast, exactly one word is sent. A dump of 0..31 sends 32 words.
- Register 0 is read through the port like any other index. The module does not force its value.
- DumpStart while DumpBusy=1 is ignored and has no queued effect.
- DumpAbort=1 in FETCH or SEND: go to IDLE next edge, clear DumpValid, no DumpDone. A word pending in SEND is discarded even if DumpReady=1 in the same cycle; abort wins. DumpAbort in IDLE or DONE has no effect.
- Register-file writes during a dump are not blocked. Each word reflects the register contents at its FETCH edge.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, cur=0, RUrsAddr=0, DumpAddr=0, DumpData=0, DumpValid=0, DumpBusy=0, DumpDone=0. RST asserted mid-dump abandons it with no DumpDone.
- Start latency: DumpStart high at edge k moves the FSM to FETCH. DumpValid rises after edge k+1.
- Throughput: at most one word per 2 cycles (FETCH+SEND) with DumpReady held high.
- Total time with DumpReady held high for an N-word dump: 2N cycles from the start edge to the last handshake. DumpDone is high in the following cycle, and DumpBusy falls one cycle after that.
- Consumer stall: DumpAddr, DumpData and DumpValid are stable while DumpValid=1 and DumpReady=0.
- DumpReady while DumpValid=0 has no effect.
- All outputs are registered except RUrsAddr, which comes directly from the cur register and so is also glitch-free.

## Test plan
- Full dump: preload reg[i]=i*3 (reg0=0), start with First=0, Last=31, DumpReady=1. Expect 32 words (i, i*3) in order, DumpDone exactly 64 cycles after the start edge, and DumpBusy low 1 cycle later.
- Wrapped range: First=30, Last=1. Expect words for indices 30,31,0,1 only, then one DumpDone pulse.
- Backpressure: First=Last=5, reg5=0xDEADBEEF, DumpReady low for 7 cycles. Expect DumpValid, DumpAddr=5 and DumpData=0xDEADBEEF held constant, then exactly one transfer when DumpReady rises.
- Abort and ignored start: during a 0..31 dump, pulse DumpStart at word 4 and expect no effect. Assert DumpAbort in SEND with DumpReady=1 at word 10. Expect DumpValid low and IDLE next cycle, no DumpDone, and word 10 not counted.
- Async reset mid-dump: assert RST between edges during FETCH. Expect all outputs 0 immediately. After release, a new dump of 7..7 works normally.
- Live write: change reg3 from 0x11 to 0x22 before its FETCH edge in a 0..5 dump. Expect word 3 to carry 0x22.

Source files
------------

// File: rtl/ru_dump_reader.sv
// Register-file dump engine: walks a (possibly wrapping) address range through a
// spare read port and streams each (index, value) pair over valid/ready.
module ru_dump_reader #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              DumpStart,
    input  logic [ADDR_W-1:0] DumpFirst,
    input  logic [ADDR_W-1:0] DumpLast,
    input  logic              DumpAbort,
    output logic [ADDR_W-1:0] RUrsAddr,
    input  logic [DATA_W-1:0] RUrsData,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic [ADDR_W-1:0] DumpAddr,
    output logic [DATA_W-1:0] DumpData,
    output logic              DumpBusy,
    output logic              DumpDone
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   cur_inc;

    // Explicit wrap so non-power-of-two NREGS still cycles modulo NREGS.
    assign cur_inc = (cur_q == ADDR_W'(NREGS - 1)) ? '0 : cur_q + ADDR_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (DumpStart) begin
                    cur_d   = DumpFirst;
                    last_d  = DumpLast;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (DumpAbort) begin
                    state_d = S_IDLE;
                end else begin
                    data_d  = RUrsData;
                    addr_d  = cur_q;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // Abort takes priority over a same-cycle handshake.
                if (DumpAbort) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (valid_q && DumpReady) begin
                    valid_d = 1'b0;
                    if (cur_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = cur_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Busy/done are registered copies of the next-state decode.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign RUrsAddr  = cur_q;
    assign DumpValid = valid_q;
    assign DumpAddr  = addr_q;
    assign DumpData  = data_q;
    assign DumpBusy  = busy_q;
    assign DumpDone  = done_q;

endmodule
